// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one write port and a registered read port.
// The read register can be cleared so the responder can return 0 for
// stores and errored requests without a second output stage.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Word write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read with clear; this register is the responder's rsp_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states,
// commit into dmem_array on entry to RESP, response held until taken.
// Optional: define DMEM_ALIGN_CHECK_EN to flag addr[1:0] != 0 as an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     AW         = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] BYTE_LIMIT = WORD_W'(4 * DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_INIT  = CNT_W'(WAIT_CYCLES);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              commit;

  logic              lat_we;
  logic [WORD_W-1:0] lat_addr, lat_wdata;

  logic              c_we;
  logic [WORD_W-1:0] c_addr, c_wdata;
  logic [AW-1:0]     c_idx;
  logic              c_bad;
  logic              arr_we, arr_rd_en, arr_rd_clr;

  // Next state, wait counter and commit strobe.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
            commit     = 1'b1;
          end else begin
            next_state = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          next_state = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Commit operands: live request when committing straight from IDLE.
  always_comb begin
    c_we    = (state == IDLE) ? req_we    : lat_we;
    c_addr  = (state == IDLE) ? req_addr  : lat_addr;
    c_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    c_idx   = c_addr[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    c_bad   = (c_addr >= BYTE_LIMIT) || (c_addr[1:0] != 2'b00);
`else
    c_bad   = (c_addr >= BYTE_LIMIT);
`endif
    arr_we     = commit & c_we & ~c_bad & ~reset;
    arr_rd_en  = commit & ~c_we & ~c_bad;
    arr_rd_clr = commit & (c_we | c_bad);
  end

  // State, counter, latched request and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      req_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
      if (commit) begin
        rsp_err <= c_bad;
      end
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (arr_we),
    .waddr  (c_idx),
    .wdata  (c_wdata),
    .rd_en  (arr_rd_en),
    .rd_clr (arr_rd_clr),
    .raddr  (c_idx),
    .rdata  (rsp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 instance (vector table,
// backpressure, reset corners) and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit z, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (z) begin
      z_req_valid = v; z_req_we = we; z_req_addr = a; z_req_wdata = d;
    end else begin
      req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    end
  endtask

  // Wait (bounded) at negedges for rsp_valid; returns cycles since accept edge.
  task automatic wait_rsp(input bit z, output int n);
    logic v;
    n = 0;
    v = 1'b0;
    while (!v && n < 40) begin
      @(negedge clk);
      n++;
      v = z ? z_rsp_valid : rsp_valid;
    end
  endtask

  // One full transaction with rsp_ready high; starts and ends at a negedge.
  task automatic txn(input bit z, input string nm, input logic we,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int n;
    check({nm, " req_ready before"}, 32'(z ? z_req_ready : req_ready), 32'd1);
    drive(z, 1'b1, we, a, d);
    @(posedge clk);
    #1 drive(z, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(z, n);
    check({nm, " latency"}, 32'(n), 32'(exp_lat));
    check({nm, " rdata"}, z ? z_rsp_rdata : rsp_rdata, exp_rd);
    check({nm, " err"}, 32'(z ? z_rsp_err : rsp_err), 32'(exp_err));
    @(negedge clk);
    check({nm, " req_ready after"}, 32'(z ? z_req_ready : req_ready), 32'd1);
    check({nm, " rsp_valid after"}, 32'(z ? z_rsp_valid : rsp_valid), 32'd0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 32'd100,        32'd25,         32'd0,          1'b0};
    vecs[1]  = '{1'b0, 32'd100,        32'd0,          32'd25,         1'b0};
    vecs[2]  = '{1'b1, 32'd0,          32'hA5A5_0001,  32'd0,          1'b0};
    vecs[3]  = '{1'b1, 32'd256,        32'h0000_1234,  32'd0,          1'b1};
    vecs[4]  = '{1'b0, 32'd0,          32'd0,          32'hA5A5_0001,  1'b0};
    vecs[5]  = '{1'b0, 32'd256,        32'd0,          32'd0,          1'b1};
    vecs[6]  = '{1'b1, 32'd252,        32'hCAFE_F00D,  32'd0,          1'b0};
    vecs[7]  = '{1'b0, 32'd252,        32'd0,          32'hCAFE_F00D,  1'b0};
    vecs[8]  = '{1'b1, 32'd4,          32'hDEAD_BEEF,  32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'd4,          32'd0,          32'hDEAD_BEEF,  1'b0};
    vecs[10] = '{1'b1, 32'd8,          32'h0BAD_0008,  32'd0,          1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC,  32'd0,          32'd0,          1'b1};
    vecs[12] = '{1'b1, 32'd102,        32'h0000_0077,  32'd0,          ALIGN};
    vecs[13] = '{1'b0, 32'd100,        32'd0,          ALIGN ? 32'd25 : 32'h77, 1'b0};
    vecs[14] = '{1'b0, 32'd103,        32'd0,          ALIGN ? 32'd0 : 32'h77,  ALIGN};
    vecs[15] = '{1'b0, 32'd255,        32'd0,          ALIGN ? 32'd0 : 32'hCAFE_F00D, ALIGN};

    reset = 1'b1;
    rsp_ready = 1'b1;
    z_rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset z req_ready", 32'(z_req_ready), 32'd1);
    check("reset z rsp_valid", 32'(z_rsp_valid), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      txn(1'b0, $sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
          vecs[i].rdata, vecs[i].err, 3);
    end

    // Backpressure: response held, second request held pending.
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    wait_rsp(1'b0, n);
    check("bp latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("bp hold%0d valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp hold%0d rdata", i), rsp_rdata, 32'hDEAD_BEEF);
      check($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp req_ready back", 32'(req_ready), 32'd1);
    check("bp rsp_valid drop", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(1'b0, n);
    check("bp second latency", 32'(n), 32'd3);
    check("bp second rdata", rsp_rdata, 32'hA5A5_0001);
    @(negedge clk);

    // Reset while in WAIT drops the pending store.
    drive(1'b0, 1'b1, 1'b1, 32'd8, 32'h5555_5555);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst rsp_rdata", rsp_rdata, 32'd0);
    check("midrst rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst no late rsp", 32'(rsp_valid), 32'd0);
    txn(1'b0, "midrst load8", 1'b0, 32'd8, 32'd0, 32'h0BAD_0008, 1'b0, 3);

    // Reset while in RESP keeps the already committed store.
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'd8, 32'h2222_3333);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_rsp(1'b0, n);
    check("resprst latency", 32'(n), 32'd3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    check("resprst rsp_valid", 32'(rsp_valid), 32'd0);
    txn(1'b0, "resprst load8", 1'b0, 32'd8, 32'd0, 32'h2222_3333, 1'b0, 3);

    // Zero wait states.
    txn(1'b1, "z store12", 1'b1, 32'd12, 32'h0000_600D, 32'd0, 1'b0, 1);
    txn(1'b1, "z load12", 1'b0, 32'd12, 32'd0, 32'h0000_600D, 1'b0, 1);
    txn(1'b1, "z load256", 1'b0, 32'd256, 32'd0, 32'd0, 1'b1, 1);
    txn(1'b1, "z load12b", 1'b0, 32'd12, 32'd0, 32'h0000_600D, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the memory-side end of the core's load/store port. It accepts one word request at a time over a valid/ready handshake, inserts a configurable number of wait states, commits stores into a word array, and returns load data or completion with an error flag. It sits between the core's memory stage and the on-chip data RAM, replacing the zero-latency combinational data memory.

## Interface
- DEPTH, 64: number of 32-bit words. Must be a power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states inserted between accept and response. Legal range is 0–15.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; the initiator holds all req_* stable until accepted.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present; held until rsp_ready.
- rsp_ready  input  1  initiator takes the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was out of range (or misaligned, see Configuration).

## Operation
- States:
  - IDLE: req_ready=1.
  - WAIT: counting down wait states.
  - RESP: rsp_valid=1.
- Accept: a request is accepted when req_valid & req_ready.
  - we, addr and wdata are latched.
  - The wait counter is loaded with WAIT_CYCLES.
  - Next state is WAIT, or RESP directly if WAIT_CYCLES=0.
- WAIT: the counter decrements each cycle. When it reaches 1, the next state is RESP.
- Commit on the IDLE/WAIT→RESP transition edge:
  - Store: the word is written if in range.
  - Load: the word is read into the rsp_rdata register.
- Address decode:
  - Word index = addr[$clog2(DEPTH)+1:2].
  - An address is in range iff addr < 4*DEPTH.
  - Out of range: the store is suppressed, rsp_rdata=0, rsp_err=1.
- RESP: outputs are held stable while rsp_ready=0. When rsp_valid & rsp_ready, go to IDLE.
- No overlap: req_ready=0 in WAIT and RESP. req_valid in those states is ignored and stays pending.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Array contents are not reset.
- Reset mid-operation (reset in WAIT): the pending store is dropped and the array is unchanged. A store already committed on entering RESP is kept.
- Store writes all 4 bytes. There are no byte enables.

## Timing
- Request accepted on the edge ending cycle T. rsp_valid is first high in cycle T+1+WAIT_CYCLES.
- The array is updated by the edge ending cycle T+WAIT_CYCLES.
- With rsp_ready tied high, rsp_valid is high for exactly one cycle.
  - req_ready returns high in cycle T+2+WAIT_CYCLES.
  - Peak throughput is one request per WAIT_CYCLES+2 cycles.
- A load to an address stored by the previous request returns the new data; the commits are ordered.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: addr[1:0] ≠ 0 causes an error response.
  - rsp_err=1 and rsp_rdata=0.
  - The store is suppressed.
  - Latency is unchanged.
- DMEM_ALIGN_CHECK_EN undefined: addr[1:0] is ignored. Only the range check can raise rsp_err.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the wait-counter width constant (4);
  - the word width constant (32).
- Sub-module dmem_array holds the DEPTH×32 storage.
  - Ports: single write port (we, waddr, wdata) and registered read (raddr, rdata).
  - It is instantiated once. The responder FSM drives it at the commit edge.

## Test plan
- Store then load, with WAIT_CYCLES=2 and rsp_ready=1:
  - Store 25 at addr 100, accepted in cycle T → rsp_valid in T+3 with rsp_err=0.
  - Then load 100 → rsp_rdata=25.
- Zero wait states, WAIT_CYCLES=0: load accepted in T → rsp_valid in T+1, and req_ready high again in T+2.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load of a word containing 0xDEADBEEF.
  - rsp_valid and rsp_rdata=0xDEADBEEF stay stable.
  - req_ready stays 0 while a second req_valid is held.
  - The second request is accepted the cycle after rsp_ready=1.
- Out of range: store 0x1234 at addr 256 (DEPTH=64) → rsp_err=1. A load of addr 0 afterwards is unchanged.
- Reset mid-operation: assert reset one cycle after a store to addr 8 is accepted.
  - All outputs go to reset values.
  - A later load of addr 8 returns the old value.
- Misaligned access: store at addr 102.
  - With DMEM_ALIGN_CHECK_EN: rsp_err=1 and word 25 is unchanged.
  - Without it: word 25 is written and rsp_err=0.
